// File: rtl/divergence_context_queue.sv
// Per-warp circular queues of deferred SIMT thread contexts for branch divergence.
// Optional reconvergence merge folds a push into the tail entry when the PC matches.
module divergence_context_queue #(
    parameter int NUM_WARPS  = 4,
    parameter int DEPTH      = 64,
    parameter int LANES      = 8,
    parameter int LANE_REG_W = 256,
    parameter int PC_W       = 32,
    parameter int MERGE_EN   = 1,
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1),
    localparam int RW = LANES * LANE_REG_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push_valid,
    output logic                 push_ready,
    input  logic [WW-1:0]        push_warp,
    input  logic [RW-1:0]        push_regs,
    input  logic [PC_W-1:0]      push_pc,
    input  logic [LANES-1:0]     push_mask,
    input  logic [WW-1:0]        pop_warp,
    input  logic                 pop_en,
    output logic                 head_valid,
    output logic [RW-1:0]        head_regs,
    output logic [PC_W-1:0]      head_pc,
    output logic [LANES-1:0]     head_mask,
    output logic [CW-1:0]        head_count,
    output logic [NUM_WARPS-1:0] empty,
    output logic [NUM_WARPS-1:0] full,
    output logic                 underflow_err
);

    logic [RW-1:0]    st_regs [NUM_WARPS][DEPTH];
    logic [PC_W-1:0]  st_pc   [NUM_WARPS][DEPTH];
    logic [LANES-1:0] st_mask [NUM_WARPS][DEPTH];

    logic [PW-1:0] rd_ptr [NUM_WARPS];
    logic [PW-1:0] wr_ptr [NUM_WARPS];
    logic [CW-1:0] count  [NUM_WARPS];

    logic                 pop_fire;
    logic                 push_fire;
    logic                 merge_hit;
    logic                 head_popped;
    logic [PW-1:0]        last_idx;
    logic [PW-1:0]        wr_idx;
    logic [RW-1:0]        wr_regs;
    logic [LANES-1:0]     wr_mask;
    logic [NUM_WARPS-1:0] push_adv;
    logic [NUM_WARPS-1:0] pop_adv;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] prev_ptr(input logic [PW-1:0] p);
        return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
    endfunction

    always_comb begin
        empty = '0;
        full  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            empty[w] = (count[w] == '0);
            full[w]  = (count[w] == CW'(DEPTH));
        end
    end

    assign head_count = count[pop_warp];
    assign head_valid = (head_count != '0);
    assign head_regs  = st_regs[pop_warp][rd_ptr[pop_warp]];
    assign head_pc    = st_pc[pop_warp][rd_ptr[pop_warp]];
    assign head_mask  = st_mask[pop_warp][rd_ptr[pop_warp]];

    assign pop_fire = pop_en & head_valid;
    assign last_idx = prev_ptr(wr_ptr[push_warp]);

    // A tail entry that is also the head leaving this cycle must not absorb the push.
    assign head_popped = pop_fire && (pop_warp == push_warp)
                      && (rd_ptr[push_warp] == last_idx);

    assign merge_hit = (MERGE_EN != 0)
                    && (count[push_warp] != '0)
                    && (st_pc[push_warp][last_idx] == push_pc)
                    && !head_popped;

    assign push_ready = !full[push_warp] | merge_hit;
    assign push_fire  = push_valid & push_ready;

    always_comb begin
        wr_idx  = wr_ptr[push_warp];
        wr_regs = push_regs;
        wr_mask = push_mask;
        if (merge_hit) begin
            wr_idx  = last_idx;
            wr_regs = st_regs[push_warp][last_idx];
            wr_mask = st_mask[push_warp][last_idx] | push_mask;
            for (int i = 0; i < LANES; i++) begin
                if (push_mask[i]) begin
                    wr_regs[i*LANE_REG_W +: LANE_REG_W] =
                        push_regs[i*LANE_REG_W +: LANE_REG_W];
                end
            end
        end
    end

    always_comb begin
        push_adv = '0;
        pop_adv  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            push_adv[w] = push_fire && !merge_hit && (push_warp == WW'(w));
            pop_adv[w]  = pop_fire && (pop_warp == WW'(w));
        end
    end

    // Context storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            st_regs[push_warp][wr_idx] <= wr_regs;
            st_pc[push_warp][wr_idx]   <= push_pc;
            st_mask[push_warp][wr_idx] <= wr_mask;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                rd_ptr[w] <= '0;
                wr_ptr[w] <= '0;
                count[w]  <= '0;
            end
            underflow_err <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (push_adv[w]) begin
                    wr_ptr[w] <= next_ptr(wr_ptr[w]);
                end
                if (pop_adv[w]) begin
                    rd_ptr[w] <= next_ptr(rd_ptr[w]);
                end
                if (push_adv[w] && !pop_adv[w]) begin
                    count[w] <= count[w] + 1'b1;
                end else if (!push_adv[w] && pop_adv[w]) begin
                    count[w] <= count[w] - 1'b1;
                end
            end
            if (pop_en && !head_valid) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_divergence_context_queue.sv
// Randomized bench for divergence_context_queue against a queue-based model.
// Small build: DEPTH=5, 16-bit lanes, merge enabled.
module tb_divergence_context_queue;

    localparam int NW  = 4;
    localparam int D   = 5;
    localparam int L   = 8;
    localparam int LRW = 16;
    localparam int RW  = L * LRW;

    typedef struct {
        logic [RW-1:0] regs;
        logic [31:0]   pc;
        logic [7:0]    mask;
    } ent_t;

    logic          clk;
    logic          reset_n;
    logic          push_valid;
    logic          push_ready;
    logic [1:0]    push_warp;
    logic [RW-1:0] push_regs;
    logic [31:0]   push_pc;
    logic [7:0]    push_mask;
    logic [1:0]    pop_warp;
    logic          pop_en;
    logic          head_valid;
    logic [RW-1:0] head_regs;
    logic [31:0]   head_pc;
    logic [7:0]    head_mask;
    logic [2:0]    head_count;
    logic [3:0]    empty;
    logic [3:0]    full;
    logic          underflow_err;

    divergence_context_queue #(
        .NUM_WARPS(NW), .DEPTH(D), .LANES(L),
        .LANE_REG_W(LRW), .PC_W(32), .MERGE_EN(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_warp(push_warp), .push_regs(push_regs),
        .push_pc(push_pc), .push_mask(push_mask),
        .pop_warp(pop_warp), .pop_en(pop_en),
        .head_valid(head_valid), .head_regs(head_regs),
        .head_pc(head_pc), .head_mask(head_mask),
        .head_count(head_count), .empty(empty), .full(full),
        .underflow_err(underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t mq [NW][$];
    bit   m_uf;
    int   n_cmp;
    int   n_bad;

    logic [171:0] oh, eh;
    logic [8:0]   os, es;
    logic         ory, ery;

    function automatic logic [RW-1:0] rnd_regs();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit m_merge(int w, logic [31:0] pc, int ow, bit pe);
        if (mq[w].size() == 0) return 1'b0;
        if (mq[w][mq[w].size()-1].pc != pc) return 1'b0;
        if (pe && ow == w && mq[w].size() == 1) return 1'b0;
        return 1'b1;
    endfunction

    // Drive one cycle, capture DUT/model views before the edge, then advance the model.
    task automatic step(input bit pv, input int pw, input logic [RW-1:0] rg,
                        input logic [31:0] pc, input logic [7:0] mk,
                        input int ow, input bit pe);
        bit   mg;
        bit   rdy;
        ent_t e;
        int   idx;
        push_valid = pv;
        push_warp  = 2'(pw);
        push_regs  = rg;
        push_pc    = pc;
        push_mask  = mk;
        pop_warp   = 2'(ow);
        pop_en     = pe;
        @(negedge clk);
        mg  = m_merge(pw, pc, ow, pe);
        rdy = (mq[pw].size() < D) || mg;
        ory = push_ready;
        ery = rdy;
        if (mq[ow].size() > 0) begin
            e  = mq[ow][0];
            eh = {1'b1, 3'(mq[ow].size()), e.pc, e.mask, e.regs};
            oh = {head_valid, head_count, head_pc, head_mask, head_regs};
        end else begin
            eh = {1'b0, 3'd0, 168'd0};
            oh = {head_valid, head_count, 168'd0};
        end
        os = {empty, full, underflow_err};
        es = '0;
        for (int w = 0; w < NW; w++) begin
            es[5+w] = (mq[w].size() == 0);
            es[1+w] = (mq[w].size() == D);
        end
        es[0] = m_uf;
        if (pe) begin
            if (mq[ow].size() > 0) e = mq[ow].pop_front();
            else m_uf = 1'b1;
        end
        if (pv && rdy) begin
            if (mg) begin
                idx = mq[pw].size() - 1;
                e = mq[pw][idx];
                for (int i = 0; i < L; i++)
                    if (mk[i]) e.regs[i*LRW +: LRW] = rg[i*LRW +: LRW];
                e.mask = e.mask | mk;
                mq[pw][idx] = e;
            end else begin
                e.regs = rg;
                e.pc   = pc;
                e.mask = mk;
                mq[pw].push_back(e);
            end
        end
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        pop_en     = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n    = 1'b0;
        push_valid = 1'b0;
        pop_en     = 1'b0;
        #10;
        reset_n = 1'b1;
        for (int w = 0; w < NW; w++) mq[w].delete();
        m_uf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        push_valid = 1'b0;
        push_warp  = '0;
        push_regs  = '0;
        push_pc    = '0;
        push_mask  = '0;
        pop_warp   = '0;
        pop_en     = 1'b0;
        #23;
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (empty !== 4'hF) begin
            n_bad++;
            $display("FAIL reset_empty got %h want f", empty);
        end
        n_cmp++;
        if (full !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_full got %h want 0", full);
        end
        n_cmp++;
        if (head_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_head_valid got %b want 0", head_valid);
        end
        n_cmp++;
        if (push_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_push_ready got %b want 1", push_ready);
        end
        n_cmp++;
        if (underflow_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_underflow got %b want 0", underflow_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1, 2, rnd_regs(), 32'h100 + 32'(k), 8'($urandom), 0, 0);
            n_cmp++;
            if (ory !== ery) begin
                n_bad++;
                $display("FAIL fill_ready k=%0d got %b want %b", k, ory, ery);
            end
        end
        step(1, 2, rnd_regs(), 32'h1FF, 8'hFF, 2, 0);
        n_cmp++;
        if (ory !== 1'b0 || os[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL full_block ready=%b full2=%b want 0/1", ory, os[3]);
        end
        for (int k = 0; k < 3; k++) begin
            // The first pop shares its cycle with a push that must stay blocked.
            step(k == 0, 2, rnd_regs(), 32'h1FE, 8'hFF, 2, 1);
            n_cmp++;
            if (oh[167:136] !== 32'h100 + 32'(k) || ory !== ery) begin
                n_bad++;
                $display("FAIL wrap_pop k=%0d pc=%h ready=%b want %h/%b",
                         k, oh[167:136], ory, 32'h100 + 32'(k), ery);
            end
        end
        for (int k = 0; k < 3; k++)
            step(1, 2, rnd_regs(), 32'h105 + 32'(k), 8'($urandom), 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, '0, '0, '0, 2, 1);
            n_cmp++;
            if (oh !== eh || oh[167:136] !== 32'h103 + 32'(k)) begin
                n_bad++;
                $display("FAIL wrap_order k=%0d got %h want %h", k, oh, eh);
            end
        end
    endtask

    task automatic test_merge();
        logic [RW-1:0] r1;
        logic [RW-1:0] r2;
        do_reset();
        r1 = rnd_regs();
        r2 = rnd_regs();
        r2[4*LRW +: LRW] = 16'hAAAA;
        step(1, 0, r1, 32'h40, 8'h0F, 0, 0);
        step(1, 0, r2, 32'h40, 8'hF0, 0, 0);
        n_cmp++;
        if (ory !== 1'b1 || ery !== 1'b1) begin
            n_bad++;
            $display("FAIL merge_ready got %b want 1", ory);
        end
        step(0, 0, '0, '0, '0, 0, 0);
        n_cmp++;
        if (oh !== eh) begin
            n_bad++;
            $display("FAIL merge_model got %h want %h", oh, eh);
        end
        n_cmp++;
        if (head_count !== 3'd1 || head_mask !== 8'hFF) begin
            n_bad++;
            $display("FAIL merge_mask cnt=%0d mask=%h want 1/ff", head_count, head_mask);
        end
        n_cmp++;
        if (head_regs[4*LRW +: LRW] !== 16'hAAAA
            || head_regs[4*LRW-1:0] !== r1[4*LRW-1:0]
            || head_regs[RW-1:5*LRW] !== r2[RW-1:5*LRW]) begin
            n_bad++;
            $display("FAIL merge_regs got %h want lanes0-3 %h lane4 aaaa",
                     head_regs, r1[4*LRW-1:0]);
        end
    endtask

    task automatic test_merge_bypass();
        do_reset();
        step(1, 1, rnd_regs(), 32'h80, 8'h0F, 1, 0);
        step(1, 1, rnd_regs(), 32'h80, 8'h3C, 1, 1);
        n_cmp++;
        if (ory !== 1'b1 || ory !== ery) begin
            n_bad++;
            $display("FAIL bypass_ready got %b want %b", ory, ery);
        end
        step(0, 0, '0, '0, '0, 1, 0);
        n_cmp++;
        if (head_count !== 3'd1 || head_pc !== 32'h80 || head_mask !== 8'h3C) begin
            n_bad++;
            $display("FAIL bypass_head cnt=%0d pc=%h mask=%h want 1/80/3c",
                     head_count, head_pc, head_mask);
        end
        n_cmp++;
        if (oh !== eh) begin
            n_bad++;
            $display("FAIL bypass_model got %h want %h", oh, eh);
        end
    endtask

    task automatic test_concurrent();
        do_reset();
        for (int k = 0; k < 4; k++)
            step(1, 0, rnd_regs(), 32'h500 + 32'(k), 8'($urandom), 0, 0);
        for (int k = 0; k < 20; k++) begin
            step($urandom_range(0, 3) != 0, 3, rnd_regs(),
                 32'h200 + 32'($urandom_range(0, 2) * 4), 8'($urandom),
                 0, 1'($urandom_range(0, 1)));
            n_cmp++;
            if (ory !== ery || oh !== eh || os !== es) begin
                n_bad++;
                $display("FAIL concurrent k=%0d rdy=%b/%b head=%h/%h stat=%h/%h",
                         k, ory, ery, oh, eh, os, es);
            end
        end
        for (int w = 0; w < NW; w++) begin
            step(0, 0, '0, '0, '0, w, 0);
            n_cmp++;
            if (oh !== eh) begin
                n_bad++;
                $display("FAIL concurrent_final w=%0d got %h want %h", w, oh, eh);
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        step(0, 0, '0, '0, '0, 1, 1);
        step(0, 0, '0, '0, '0, 1, 0);
        n_cmp++;
        if (underflow_err !== 1'b1 || os !== es) begin
            n_bad++;
            $display("FAIL underflow_set err=%b stat=%h want 1/%h", underflow_err, os, es);
        end
        step(1, 1, rnd_regs(), 32'h55, 8'h11, 0, 0);
        step(0, 0, '0, '0, '0, 1, 0);
        n_cmp++;
        if (oh !== eh || head_pc !== 32'h55 || head_count !== 3'd1) begin
            n_bad++;
            $display("FAIL underflow_ptrs got %h want %h", oh, eh);
        end
        n_cmp++;
        if (underflow_err !== 1'b1) begin
            n_bad++;
            $display("FAIL underflow_sticky got %b want 1", underflow_err);
        end
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (underflow_err !== 1'b0) begin
            n_bad++;
            $display("FAIL underflow_clear got %b want 0", underflow_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3), rnd_regs(),
                 32'h300 + 32'($urandom_range(0, 3) * 4), 8'($urandom),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            n_cmp++;
            if (ory !== ery || oh !== eh || os !== es) begin
                n_bad++;
                $display("FAIL random k=%0d rdy=%b/%b head=%h/%h stat=%h/%h",
                         k, ory, ery, oh, eh, os, es);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_uf  = 1'b0;
        test_reset();
        test_fill_wrap();
        test_merge();
        test_merge_bypass();
        test_concurrent();
        test_underflow();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
